// File: rtl/md_pkg.sv
// Shared types and sizing helpers for the multiply/divide control slice.
package md_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } md_state_t;

    localparam int MUL_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF = 10;

    function automatic int cnt_width(input int mul_cycles, input int div_cycles);
        return $clog2(((mul_cycles > div_cycles) ? mul_cycles : div_cycles) + 1);
    endfunction

    localparam int CNT_W = cnt_width(MUL_CYCLES_DEF, DIV_CYCLES_DEF);

endpackage

// File: rtl/md_datapath.sv
// Combinational multiply/divide results for HI/LO, including the
// divide-by-zero flag and the signed INT_MIN / -1 overflow case.
module md_datapath
    import md_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div0
);

    logic signed [63:0] a_ext;
    logic signed [63:0] b_ext;
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic signed [31:0] a_s;
    logic signed [31:0] b_safe_s;
    logic signed [31:0] quot_s;
    logic signed [31:0] rem_s;
    logic        [31:0] b_safe_u;
    logic               div_ovf;

    always_comb begin
        a_ext  = {{32{A[31]}}, A};
        b_ext  = {{32{B[31]}}, B};
        prod_s = a_ext * b_ext;
        prod_u = {32'd0, A} * {32'd0, B};

        div0    = (B == 32'd0);
        div_ovf = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);

        // Substitute a divisor of 1 so neither zero nor overflow reaches the divider.
        a_s      = $signed(A);
        b_safe_s = (div0 || div_ovf) ? 32'sd1 : $signed(B);
        b_safe_u = div0 ? 32'd1 : B;
        quot_s   = a_s / b_safe_s;
        rem_s    = a_s % b_safe_s;

        res_hi = 32'd0;
        res_lo = 32'd0;
        case (md_op_t'(op))
            OP_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            OP_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            OP_DIV: begin
                res_hi = rem_s;
                res_lo = quot_s;
            end
            OP_DIVU: begin
                res_hi = A % b_safe_u;
                res_lo = A / b_safe_u;
            end
            default: begin
                res_hi = 32'd0;
                res_lo = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// EX-stage multiply/divide sequencer: launches ops, tracks occupancy and
// owns the architectural HI/LO registers.
module muldiv_ctrl
    import md_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic        cancel,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        state,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int CW = cnt_width(MUL_CYCLES, DIV_CYCLES);

    md_state_t      fsm_q, fsm_d;
    logic [CW-1:0]  cnt_q;
    logic [31:0]    pend_hi, pend_lo;
    logic           pend_div0;
    logic [31:0]    res_hi, res_lo;
    logic           div0;
    logic           accept, is_mul, is_div, done;

    md_datapath u_datapath (
        .op     (op),
        .A      (A),
        .B      (B),
        .res_hi (res_hi),
        .res_lo (res_lo),
        .div0   (div0)
    );

    assign accept = start && !cancel && !busy && (op <= 3'(OP_MTLO));
    assign is_mul = (op == 3'(OP_MULT)) || (op == 3'(OP_MULTU));
    assign is_div = (op == 3'(OP_DIV))  || (op == 3'(OP_DIVU));
    assign state  = accept && (op <= 3'(OP_DIVU));
    assign done   = busy && (cnt_q == CW'(1));

    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            IDLE: begin
                if (accept && is_mul)
                    fsm_d = MUL;
                else if (accept && is_div)
                    fsm_d = DIV;
            end
            MUL, DIV: begin
                if (cnt_q == CW'(1))
                    fsm_d = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q     <= IDLE;
            cnt_q     <= '0;
            busy      <= 1'b0;
            pend_hi   <= '0;
            pend_lo   <= '0;
            pend_div0 <= 1'b0;
            HI        <= '0;
            LO        <= '0;
        end else begin
            fsm_q <= fsm_d;
            if (state) begin
                pend_hi   <= res_hi;
                pend_lo   <= res_lo;
                pend_div0 <= is_div && div0;
                cnt_q     <= is_mul ? CW'(MUL_CYCLES) : CW'(DIV_CYCLES);
                busy      <= 1'b1;
            end else if (busy) begin
                cnt_q <= cnt_q - CW'(1);
                if (done) begin
                    busy <= 1'b0;
                    // A zero divisor still occupies the unit but leaves HI/LO intact.
                    if (!pend_div0) begin
                        HI <= pend_hi;
                        LO <= pend_lo;
                    end
                end
            end else if (accept && (op == 3'(OP_MTHI))) begin
                HI <= A;
            end else if (accept && (op == 3'(OP_MTLO))) begin
                LO <= A;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed-vector bench for muldiv_ctrl with hand-computed HI/LO results.
module tb_muldiv_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic        cancel;
    logic [31:0] A;
    logic [31:0] B;
    logic        state;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks;
    int errors;

    muldiv_ctrl #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .cancel (cancel),
        .A      (A),
        .B      (B),
        .state  (state),
        .busy   (busy),
        .HI     (HI),
        .LO     (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Illegal-use monitor: the hazard unit must never issue while busy or with a reserved op.
    always @(posedge clk) begin
        if (rst_n === 1'b1 && start === 1'b1 && (busy === 1'b1 || op > 3'd5)) begin
            errors = errors + 1;
            $display("FAIL illegal_start: start=1 busy=%0b op=%0d, required no start while busy or reserved op",
                     busy, op);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        start  = 1'b0;
        cancel = 1'b0;
        op     = 3'd0;
        A      = 32'd0;
        B      = 32'd0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        drive_idle();
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || state !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            errors++;
            $display("FAIL reset: busy=%0b state=%0b HI=%h LO=%h, required 0 0 0 0", busy, state, HI, LO);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_mult();
        start = 1'b1; op = 3'd0; A = 32'hFFFF_FFFE; B = 32'd3;
        #1;
        checks++;
        if (state !== 1'b1) begin
            errors++;
            $display("FAIL mult_state: state=%0b, required 1", state);
        end
        @(posedge clk); #1;
        drive_idle();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL mult_busy[%0d]: busy=%0b, required 1", i, busy);
            end
            tick();
        end
        checks++;
        if (busy !== 1'b0 || HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFA) begin
            errors++;
            $display("FAIL mult_result: busy=%0b HI=%h LO=%h, required 0 ffffffff fffffffa", busy, HI, LO);
        end
    endtask

    task automatic test_back_to_back();
        start = 1'b1; op = 3'd3; A = 32'd7; B = 32'd2;
        tick();
        drive_idle();
        for (int i = 0; i < 9; i++) tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL divu_busy_last: busy=%0b, required 1", busy);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || HI !== 32'd1 || LO !== 32'd3) begin
            errors++;
            $display("FAIL divu_result: busy=%0b HI=%h LO=%h, required 0 00000001 00000003", busy, HI, LO);
        end
        start = 1'b1; op = 3'd2; A = 32'hFFFF_FFF9; B = 32'd2;
        #1;
        checks++;
        if (state !== 1'b1) begin
            errors++;
            $display("FAIL b2b_state: state=%0b, required 1", state);
        end
        @(posedge clk); #1;
        drive_idle();
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (busy !== 1'b0 || HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFD) begin
            errors++;
            $display("FAIL div_result: busy=%0b HI=%h LO=%h, required 0 ffffffff fffffffd", busy, HI, LO);
        end
    endtask

    task automatic test_div_zero();
        start = 1'b1; op = 3'd4; A = 32'h11;
        #1;
        checks++;
        if (state !== 1'b0) begin
            errors++;
            $display("FAIL mthi_state: state=%0b, required 0", state);
        end
        @(posedge clk); #1;
        op = 3'd5; A = 32'h22;
        tick();
        drive_idle();
        checks++;
        if (busy !== 1'b0 || HI !== 32'h11 || LO !== 32'h22) begin
            errors++;
            $display("FAIL mthi_mtlo: busy=%0b HI=%h LO=%h, required 0 00000011 00000022", busy, HI, LO);
        end
        start = 1'b1; op = 3'd2; A = 32'd100; B = 32'd0;
        tick();
        drive_idle();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (busy !== 1'b1 || HI !== 32'h11 || LO !== 32'h22) begin
                errors++;
                $display("FAIL div0_hold[%0d]: busy=%0b HI=%h LO=%h, required 1 00000011 00000022", i, busy, HI, LO);
            end
            tick();
        end
        checks++;
        if (busy !== 1'b0 || HI !== 32'h11 || LO !== 32'h22) begin
            errors++;
            $display("FAIL div0_after: busy=%0b HI=%h LO=%h, required 0 00000011 00000022", busy, HI, LO);
        end
    endtask

    task automatic test_div_overflow();
        start = 1'b1; op = 3'd2; A = 32'h8000_0000; B = 32'hFFFF_FFFF;
        tick();
        drive_idle();
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'h8000_0000) begin
            errors++;
            $display("FAIL div_ovf: busy=%0b HI=%h LO=%h, required 0 00000000 80000000", busy, HI, LO);
        end
    endtask

    task automatic test_cancel_launch();
        start = 1'b1; cancel = 1'b1; op = 3'd0; A = 32'd9; B = 32'd9;
        #1;
        checks++;
        if (state !== 1'b0) begin
            errors++;
            $display("FAIL cancel_state: state=%0b, required 0", state);
        end
        @(posedge clk); #1;
        drive_idle();
        tick();
        checks++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'h8000_0000) begin
            errors++;
            $display("FAIL cancel_noop: busy=%0b HI=%h LO=%h, required 0 00000000 80000000", busy, HI, LO);
        end
    endtask

    task automatic test_cancel_busy();
        start = 1'b1; op = 3'd1; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF;
        tick();
        drive_idle();
        tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL cancel_busy_hold: busy=%0b, required 1", busy);
        end
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (busy !== 1'b0 || HI !== 32'hFFFF_FFFE || LO !== 32'h0000_0001) begin
            errors++;
            $display("FAIL multu_result: busy=%0b HI=%h LO=%h, required 0 fffffffe 00000001", busy, HI, LO);
        end
    endtask

    task automatic test_reset_midop();
        start = 1'b1; op = 3'd3; A = 32'd50; B = 32'd7;
        tick();
        drive_idle();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            errors++;
            $display("FAIL reset_midop: busy=%0b HI=%h LO=%h, required 0 0 0", busy, HI, LO);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        checks++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            errors++;
            $display("FAIL reset_no_late_write: busy=%0b HI=%h LO=%h, required 0 0 0", busy, HI, LO);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_mult();
        test_back_to_back();
        test_div_zero();
        test_div_overflow();
        test_cancel_launch();
        test_cancel_busy();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, required completion within 100000 time units");
        $fatal(1, "timeout");
    end

endmodule
